// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the mmio_unit I/O page.
//   PAGE            - io_addr[15:8] value that selects this block
//   OFF_*           - word-aligned register offsets within the page
//   ST_*            - bit positions inside the status registers
package mmio_pkg;

    localparam logic [7:0] PAGE = 8'hFF;

    localparam logic [7:0] OFF_LED        = 8'h00;
    localparam logic [7:0] OFF_OUT_STATUS = 8'h04;
    localparam logic [7:0] OFF_OUT_DATA   = 8'h08;
    localparam logic [7:0] OFF_IN_STATUS  = 8'h0C;
    localparam logic [7:0] OFF_IN_DATA    = 8'h10;
    localparam logic [7:0] OFF_SW         = 8'h14;
    localparam logic [7:0] OFF_CYCLE      = 8'h18;

    localparam int ST_NOT_FULL = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_IN_VALID = 0;

endpackage

// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo: synchronous FIFO for the byte-output channel.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_push/i_push_data- write request and byte; ignored while full
//   i_pop             - read request; ignored while empty
//   o_full, o_empty   - status from the current (pre-edge) state
//   o_head            - oldest byte, forced to 0 while empty
// Full/empty use pointers one bit wider than the address so that
// equal addresses can be told apart by the wrap bit.
module mmio_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
    // Full is judged before the edge: a same-cycle pop does not make room.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/mmio_unit.sv
// mmio_unit: memory-mapped peripherals on the 0xFF00-0xFFFF I/O page.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   io_addr/io_dout/io_we/io_rd - CPU I/O bus; io_din is combinational
//   led                       - LED register
//   sw                        - asynchronous switches (2-flop synchronized)
//   tx_data/tx_valid/tx_ready - output FIFO drain port
//   rx_data/rx_valid/rx_ready - single-entry input mailbox fill port
// Build option: define MMIO_CYCLE_CNT_EN to build the 32-bit CYCLE counter
// at offset 0x18; otherwise that offset reads 0.
module mmio_unit
    import mmio_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int LED_W    = 16,
    parameter int SW_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      io_addr,
    input  logic [31:0]      io_dout,
    input  logic             io_we,
    input  logic             io_rd,
    output logic [31:0]      io_din,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  sw,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [31:0]      rx_data,
    input  logic             rx_valid,
    output logic             rx_ready
);
    logic             w_sel;
    logic [7:0]       w_off;
    logic             w_wr;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_mb_clear;
    logic             w_mb_fill;
    logic             w_unused;

    logic [LED_W-1:0] r_led;
    logic             r_ovf;
    logic             r_mb_valid;
    logic [31:0]      r_mb_data;
    logic [SW_W-1:0]  r_sw_meta;
    logic [SW_W-1:0]  r_sw_sync;

    assign w_sel  = (io_addr[15:8] == PAGE);
    assign w_off  = {io_addr[7:2], 2'b00};
    assign w_wr   = io_we & w_sel;
    assign w_push = w_wr & (w_off == OFF_OUT_DATA);
    // Reading IN_DATA while empty is harmless: nothing to clear.
    assign w_mb_clear = io_rd & w_sel & (w_off == OFF_IN_DATA) & r_mb_valid;
    assign w_mb_fill  = rx_valid & ~r_mb_valid;
    assign w_unused   = ^{io_addr[1:0], io_dout};

    mmio_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .W     (8)
    ) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (io_dout[7:0]),
        .i_pop       (tx_ready),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (tx_data)
    );

    assign tx_valid = ~w_empty;
    assign rx_ready = ~r_mb_valid;
    assign led      = r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led      <= '0;
            r_ovf      <= 1'b0;
            r_mb_valid <= 1'b0;
            r_mb_data  <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (w_wr && w_off == OFF_LED) r_led <= io_dout[LED_W-1:0];
            // Set and W1C clear target different offsets, so never collide.
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr && w_off == OFF_OUT_STATUS && io_dout[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
            // Fill needs valid low, clear needs valid high: mutually exclusive.
            if (w_mb_fill) begin
                r_mb_valid <= 1'b1;
                r_mb_data  <= rx_data;
            end else if (w_mb_clear) begin
                r_mb_valid <= 1'b0;
            end
        end
    end

`ifdef MMIO_CYCLE_CNT_EN
    logic [31:0] r_cycle;
    always_ff @(posedge clk) begin
        if (rst) r_cycle <= '0;
        else     r_cycle <= r_cycle + 32'd1;
    end
`endif

    always_comb begin
        io_din = '0;
        if (w_sel) begin
            case (w_off)
                OFF_LED: io_din = 32'(r_led);
                OFF_OUT_STATUS: begin
                    io_din[ST_NOT_FULL] = ~w_full;
                    io_din[ST_EMPTY]    = w_empty;
                    io_din[ST_OVF]      = r_ovf;
                end
                OFF_IN_STATUS: io_din[ST_IN_VALID] = r_mb_valid;
                OFF_IN_DATA:   io_din = r_mb_data;
                OFF_SW:        io_din = 32'(r_sw_sync);
`ifdef MMIO_CYCLE_CNT_EN
                OFF_CYCLE:     io_din = r_cycle;
`endif
                default:       io_din = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_unit.sv
// Directed testbench for mmio_unit. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge in between.
module tb_mmio_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] io_addr = '0;
    logic [31:0] io_dout = '0;
    logic        io_we = 1'b0;
    logic        io_rd = 1'b0;
    logic [31:0] io_din;
    logic [15:0] led;
    logic [15:0] sw = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mmio_unit #(.TX_DEPTH(8), .LED_W(16), .SW_W(16)) dut (
        .clk(clk), .rst(rst),
        .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd),
        .io_din(io_din), .led(led), .sw(sw),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        io_addr = a; io_dout = d; io_we = 1'b1;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        io_addr = a; io_rd = 1'b0;
        #1 d = io_din;
    endtask

    // Read with the strobe asserted across one rising edge.
    task automatic rd_strobe(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        io_addr = a; io_rd = 1'b1;
        #1 d = io_din;
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] c0;
        logic [31:0] c1;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(16'hFF00, v); check("rst_led_reg", v, 32'h0);
        rd(16'hFF04, v); check("rst_out_stat", v, 32'h3);
        rd(16'hFF0C, v); check("rst_in_stat", v, 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h1);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);

        // LED and page decode
        wr(16'hFF00, 32'h0000ABCD);
        check("led_write", 32'(led), 32'h0000ABCD);
        wr(16'h0100, 32'h00001234);
        check("led_off_page", 32'(led), 32'h0000ABCD);
        rd(16'h0100, v); check("off_page_rd", v, 32'h0);
        rd(16'hFF02, v); check("led_rd_lowbits", v, 32'h0000ABCD);
        wr(16'hFF1C, 32'hFFFFFFFF);
        rd(16'hFF1C, v); check("unmapped_rd", v, 32'h0);

        // Fill FIFO, overflow, drain
        for (int i = 0; i < 8; i++) wr(16'hFF08, 32'h41 + i);
        rd(16'hFF04, v); check("fifo_full_st", v, 32'h0);
        check("head_first", 32'(tx_data), 32'h41);
        wr(16'hFF08, 32'h49);
        rd(16'hFF04, v); check("ovf_set", v, 32'h4);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check("drain_byte", 32'(tx_data), 32'h41 + i);
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("drain_empty", 32'(tx_valid), 32'h0);
        rd(16'hFF04, v); check("empty_ovf_st", v, 32'h7);
        wr(16'hFF04, 32'h4);
        rd(16'hFF04, v); check("ovf_clear", v, 32'h3);

        // Mailbox
        rx_data = 32'hDEADBEEF; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 32'h0;
        rd(16'hFF0C, v); check("mb_valid", v, 32'h1);
        check("mb_rx_ready0", 32'(rx_ready), 32'h0);
        rd_strobe(16'hFF10, v); check("mb_data", v, 32'hDEADBEEF);
        rd(16'hFF0C, v); check("mb_cleared", v, 32'h0);
        check("mb_rx_ready1", 32'(rx_ready), 32'h1);
        rd_strobe(16'hFF10, v); check("mb_stale", v, 32'hDEADBEEF);
        rd(16'hFF0C, v); check("mb_still_empty", v, 32'h0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) wr(16'hFF08, 32'h60 + i);
        @(negedge clk);
        io_addr = 16'hFF08; io_dout = 32'h55; io_we = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        io_we = 1'b0; tx_ready = 1'b0;
        rd(16'hFF04, v); check("pp_full_st", v, 32'h5);
        tx_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            #1 check("pp_drain", 32'(tx_data), 32'h60 + i);
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("pp_count7", 32'(tx_valid), 32'h0);
        wr(16'hFF04, 32'h4);

        // Switch synchronizer latency
        sw = 16'h5A5A;
        @(negedge clk);
        rd(16'hFF14, v); check("sw_lat1", v, 32'h0);
        @(negedge clk);
        rd(16'hFF14, v); check("sw_lat2", v, 32'h00005A5A);

        // Cycle counter
        rd(16'hFF18, c0);
        repeat (10) @(negedge clk);
        rd(16'hFF18, c1);
`ifdef MMIO_CYCLE_CNT_EN
        check("cycle_delta", c1 - c0, 32'd10);
`else
        check("cycle_rd0", c0, 32'h0);
        check("cycle_rd1", c1, 32'h0);
`endif

        // Reset mid-operation, with a same-cycle LED write
        wr(16'hFF08, 32'h11);
        wr(16'hFF08, 32'h22);
        rx_data = 32'h12345678; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("pre_rst_txv", 32'(tx_valid), 32'h1);
        rst = 1'b1; io_addr = 16'hFF00; io_dout = 32'hFFFF; io_we = 1'b1;
        @(negedge clk);
        rst = 1'b0; io_we = 1'b0;
        check("mid_rst_txv", 32'(tx_valid), 32'h0);
        check("mid_rst_txd", 32'(tx_data), 32'h0);
        check("mid_rst_rxr", 32'(rx_ready), 32'h1);
        check("mid_rst_led", 32'(led), 32'h0);
        rd(16'hFF10, v); check("mid_rst_mbw", v, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmio_unit.md
# mmio_unit

Memory-mapped I/O peripheral block on the data-memory unit's I/O bus, decoding the 0xFF00–0xFFFF page. It consumes io_addr/io_dout/io_we/io_rd and returns io_din, which the data-memory unit selects whenever dmu_addr[15:8] == 8'hFF. It provides an LED register, synchronized switch inputs, a buffered byte-output channel with a valid/ready drain port, a single-entry input mailbox with a valid/ready fill port, and an optional cycle counter.

## Interface
- TX_DEPTH, 8, output FIFO depth in bytes; power of two, ≥ 2
- LED_W, 16, LED register width
- SW_W, 16, switch input width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- io_addr  in  16  byte address from the data-memory unit
- io_dout  in  32  write data from the CPU
- io_we  in  1  write strobe; asserted for every store, so the page must be decoded
- io_rd  in  1  read strobe
- io_din  out  32  read data, combinational from io_addr
- led  out  LED_W  LED register
- sw  in  SW_W  raw switches, asynchronous
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO not empty
- tx_ready  in  1  external consumer accepts the head byte
- rx_data  in  32  external input word
- rx_valid  in  1  input word offered
- rx_ready  out  1  mailbox empty

## Operation
- Decode: the access is selected only when io_addr[15:8] == 8'hFF. Offset = io_addr[7:0]; bits [1:0] are ignored.
- Outside the page, writes have no effect and io_din = 0. Unmapped offsets read 0 and ignore writes.
- 0x00 LED (RW): the write stores io_dout[LED_W-1:0]. Reads are zero-extended.
- 0x04 OUT_STATUS (R/W1C): bit0 = not full, bit1 = empty, bit2 = overflow (sticky). Writing 1 to bit2 clears it.
- 0x08 OUT_DATA (W): pushes io_dout[7:0]. If the FIFO is full, the byte is dropped and overflow is set.
- 0x0C IN_STATUS (R): bit0 = mailbox valid.
- 0x10 IN_DATA (R): returns the mailbox word. A read with io_rd clears valid at the clock edge. A read while empty returns the stale word and has no side effect.
- 0x14 SW (R): sw after a 2-flop synchronizer, zero-extended.
- 0x18 CYCLE (R): 32-bit free-running counter that wraps at 2^32.
- Output FIFO:
  - Pop on tx_valid & tx_ready.
  - Full and empty are evaluated on pre-edge state. A push while full is dropped even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers are log2(TX_DEPTH)+1 bits and wrap naturally.
- Mailbox:
  - rx_ready = !valid.
  - On rx_valid & rx_ready, latch rx_data and set valid.
  - Accept and clear cannot coincide, because ready is low while valid is set.

## Timing
- io_din is combinational: the same-cycle read supplies data for the data-memory unit's mux.
- All register writes, pushes, clears and mailbox fills take effect at the rising clk edge.
- A push is visible on tx_valid/tx_data in the following cycle. tx_data is the head byte, stable while tx_valid is high and not popped.
- After an IN_DATA read clears the mailbox, rx_ready rises the next cycle. The earliest refill is one cycle after that.
- SW latency: 2 cycles from sw to a readable value.
- Reset values: led = 0, FIFO empty (tx_valid = 0, tx_data = 0), overflow = 0, mailbox valid = 0 (rx_ready = 1), mailbox word = 0, synchronizer flops = 0, CYCLE = 0.
- Reset mid-operation discards FIFO contents and a pending mailbox word. rst dominates any same-cycle write.

## Configuration
- MMIO_CYCLE_CNT_EN
  - Defined: the CYCLE counter is built; it increments every cycle when not in reset.
  - Undefined: no counter flops are built, and offset 0x18 reads 0 like an unmapped offset.

## Structure
- Package mmio_pkg holds:
  - the page constant 8'hFF;
  - offset constants OFF_LED, OFF_OUT_STATUS, OFF_OUT_DATA, OFF_IN_STATUS, OFF_IN_DATA, OFF_SW, OFF_CYCLE;
  - status bit positions ST_NOT_FULL, ST_EMPTY, ST_OVF, ST_IN_VALID.
- Sub-module mmio_tx_fifo: parameterized synchronous FIFO with push/pop/full/empty/head. The decode, register logic and mailbox stay in mmio_unit.

## Test plan
- Reset, then read 0xFF00, 0xFF04, 0xFF0C → 0, 0x3, 0. rx_ready = 1, tx_valid = 0.
- Write 0x0000ABCD to 0xFF00 → led = 16'hABCD. Write 0x1234 to 0x0100 → led unchanged, and reading 0x0100 gives io_din = 0.
- Push 0x41..0x48 with tx_ready = 0 → OUT_STATUS = 0x0. Push 0x49 → dropped, OUT_STATUS bit2 = 1. Raise tx_ready → tx_data sequence 0x41..0x48, then tx_valid = 0. Write 0x4 to 0xFF04 → bit2 cleared.
- Hold rx_valid with rx_data = 0xDEADBEEF → IN_STATUS = 1, rx_ready = 0. Read 0xFF10 → 0xDEADBEEF, valid clears. A second 0xFF10 read has no effect.
- Full FIFO, same-cycle push 0x55 and pop → push dropped, overflow set, count = TX_DEPTH−1.
- With MMIO_CYCLE_CNT_EN: two reads of 0xFF18, 10 cycles apart → difference 10. Without the macro → reads 0. Assert rst mid-stream → FIFO empty and mailbox empty next cycle.
